// File: rtl/mha_pkg.sv
// Shared types and constants for the multi-head attention scheduler.
package mha_pkg;

    localparam int unsigned PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        PhProj    = 3'd0,
        PhCompat  = 3'd1,
        PhSoftmax = 3'd2,
        PhAttn    = 3'd3,
        PhOutProj = 3'd4
    } phase_e;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StFin
    } sched_state_e;

    function automatic phase_e next_phase(input phase_e ph);
        return phase_e'(ph + 3'd1);
    endfunction

endpackage

// File: rtl/mha_watchdog.sv
// Per-phase watchdog: cleared by i_load, counts while i_en, flags expiry at LIMIT cycles.
module mha_watchdog #(
    parameter int unsigned LIMIT = 65535,
    localparam int unsigned CNT_W = $clog2(LIMIT + 1)
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_limit;

    assign w_at_limit = (r_count >= LAST_CNT);
    // Expires on the LIMIT-th enabled cycle, so the consumer can leave that same edge.
    assign o_expired  = i_en && w_at_limit;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en && !w_at_limit) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/mha_scheduler.sv
// Sequences every head through PROJ/COMPAT/SOFTMAX/ATTN, then one OUT_PROJ phase.
// Optional phase watchdog built only when MHA_SCHED_TIMEOUT_EN is defined.
module mha_scheduler
    import mha_pkg::*;
#(
    parameter int unsigned N_HEADS        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    localparam int unsigned HEAD_W        = (N_HEADS > 1) ? $clog2(N_HEADS) : 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_init,
    output logic              o_ready,
    output logic              o_done,
    output logic              o_phase_start,
    output logic [2:0]        o_phase_sel,
    output logic [HEAD_W-1:0] o_head_idx,
    input  logic              i_phase_done,
    output logic              o_timeout_err
);

    localparam logic [HEAD_W-1:0] LAST_HEAD = HEAD_W'(N_HEADS - 1);

    sched_state_e      r_state;
    phase_e            r_phase;
    logic [HEAD_W-1:0] r_head;
    logic              r_ready;
    logic              r_done;
    logic              r_phase_start;
    logic              w_expired;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= StIdle;
            r_phase       <= PhProj;
            r_head        <= '0;
            r_ready       <= 1'b1;
            r_done        <= 1'b0;
            r_phase_start <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_init) begin
                        r_state       <= StStart;
                        r_phase       <= PhProj;
                        r_head        <= '0;
                        r_ready       <= 1'b0;
                        r_phase_start <= 1'b1;
                    end
                end
                StStart: begin
                    r_phase_start <= 1'b0;
                    r_state       <= StWait;
                end
                StWait: begin
                    if (i_phase_done) begin
                        if (r_phase == PhOutProj) begin
                            r_state <= StFin;
                            r_done  <= 1'b1;
                            r_phase <= PhProj;
                        end else begin
                            r_state       <= StStart;
                            r_phase_start <= 1'b1;
                            if (r_phase != PhAttn) begin
                                r_phase <= next_phase(r_phase);
                            end else if (r_head != LAST_HEAD) begin
                                r_head  <= r_head + 1'b1;
                                r_phase <= PhProj;
                            end else begin
                                r_head  <= '0;
                                r_phase <= PhOutProj;
                            end
                        end
                    end else if (w_expired) begin
                        // Engine hung: abandon the pass without a done pulse.
                        r_state <= StIdle;
                        r_ready <= 1'b1;
                        r_phase <= PhProj;
                        r_head  <= '0;
                    end
                end
                StFin: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= StIdle;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef MHA_SCHED_TIMEOUT_EN
    logic r_timeout_err;

    mha_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (r_state == StStart),
        .i_en      (r_state == StWait),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_timeout_err <= 1'b0;
        end else if (r_state == StIdle && i_init) begin
            r_timeout_err <= 1'b0;
        end else if (r_state == StWait && !i_phase_done && w_expired) begin
            r_timeout_err <= 1'b1;
        end
    end

    assign o_timeout_err = r_timeout_err;
`else
    assign w_expired     = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

    assign o_ready       = r_ready;
    assign o_done        = r_done;
    assign o_phase_start = r_phase_start;
    assign o_phase_sel   = r_phase;
    assign o_head_idx    = r_head;

endmodule

// File: tb/tb_mha_scheduler.sv
// Self-checking bench for mha_scheduler (N_HEADS=3); watchdog cases need MHA_SCHED_TIMEOUT_EN.
module tb_mha_scheduler;

    typedef struct {
        logic [2:0] sel;
        logic [1:0] head;
    } start_t;

    typedef struct {
        logic [2:0] sel;
        logic [1:0] head;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       init;
    logic       ready;
    logic       done;
    logic       phase_start;
    logic [2:0] phase_sel;
    logic [1:0] head_idx;
    logic       phase_done;
    logic       timeout_err;

    int     checks;
    int     failures;
    int     cyc;
    int     n_starts;
    int     n_done;
    int     done_cyc;
    int     mode;        // 0: answer one cycle after start, 1: stuck high, 2: bench-driven
    logic   start_seen;
    start_t tbl[13];
    exp_t   sb_q[$];

    mha_scheduler #(
        .N_HEADS        (3),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_init        (init),
        .o_ready       (ready),
        .o_done        (done),
        .o_phase_start (phase_start),
        .o_phase_sel   (phase_sel),
        .o_head_idx    (head_idx),
        .i_phase_done  (phase_done),
        .o_timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard consumer: every start pulse must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        start_seen = phase_start;
        if (phase_start) begin
            n_starts++;
            if (sb_q.size() == 0) begin
                chk("unexpected_start", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("start_sel", int'(phase_sel), int'(e.sel));
                chk("start_head", int'(head_idx), int'(e.head));
                if (e.cyc >= 0) chk("start_cycle", cyc, e.cyc);
            end
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    // Engine model.
    always @(posedge clk) begin
        #1;
        if (mode == 0) phase_done = start_seen;
        else if (mode == 1) phase_done = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_all(input int t0);
        for (int i = 0; i < 13; i++) begin
            sb_q.push_back('{sel: tbl[i].sel, head: tbl[i].head, cyc: t0 + 1 + 2 * i});
        end
    endtask

    task automatic run_pass(input bit inject, input string tag);
        int t0;
        int d0;
        int s0;
        tick();
        t0   = cyc;
        d0   = n_done;
        s0   = n_starts;
        init = 1'b1;
        push_all(t0);
        for (int k = 0; k < 100 && n_done == d0; k++) begin
            tick();
            init = inject && (cyc == t0 + 10);
            if (cyc == t0 + 5) chk({tag, "_ready_busy"}, int'(ready), 0);
        end
        init = 1'b0;
        chk({tag, "_done_count"}, n_done - d0, 1);
        chk({tag, "_done_cycle"}, done_cyc, t0 + 27);
        chk({tag, "_starts"}, n_starts - s0, 13);
        chk({tag, "_ready_after"}, int'(ready), 1);
        chk({tag, "_sb_empty"}, sb_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

    initial begin
        int t0;
        int d0;

        tbl[0]  = '{3'd0, 2'd0}; tbl[1]  = '{3'd1, 2'd0}; tbl[2]  = '{3'd2, 2'd0};
        tbl[3]  = '{3'd3, 2'd0}; tbl[4]  = '{3'd0, 2'd1}; tbl[5]  = '{3'd1, 2'd1};
        tbl[6]  = '{3'd2, 2'd1}; tbl[7]  = '{3'd3, 2'd1}; tbl[8]  = '{3'd0, 2'd2};
        tbl[9]  = '{3'd1, 2'd2}; tbl[10] = '{3'd2, 2'd2}; tbl[11] = '{3'd3, 2'd2};
        tbl[12] = '{3'd4, 2'd0};

        checks = 0; failures = 0; n_starts = 0; n_done = 0; done_cyc = -1;
        mode = 2; start_seen = 1'b0;
        reset_n = 1'b0; init = 1'b0; phase_done = 1'b0;

        // Reset values, then idle with no init.
        repeat (3) tick();
        chk("reset_ready", int'(ready), 1);
        chk("reset_done", int'(done), 0);
        chk("reset_start", int'(phase_start), 0);
        chk("reset_sel", int'(phase_sel), 0);
        chk("reset_head", int'(head_idx), 0);
        chk("reset_timeout_err", int'(timeout_err), 0);
        reset_n = 1'b1;
        mode    = 0;
        repeat (20) tick();
        chk("idle_no_starts", n_starts, 0);
        chk("idle_ready", int'(ready), 1);

        run_pass(1'b0, "pass");
        run_pass(1'b1, "mid_init");

        // Stuck-high strobe, already high before init.
        mode = 1;
        repeat (2) tick();
        run_pass(1'b0, "stuck");
        repeat (10) tick();
        chk("stuck_idle_done", n_done, 3);
        mode = 0;
        repeat (2) tick();

        // Stray phase_done during START, then a late real strobe.
        mode = 2;
        phase_done = 1'b0;
        tick();
        t0   = cyc;
        d0   = n_done;
        init = 1'b1;
        sb_q.push_back('{sel: 3'd0, head: 2'd0, cyc: t0 + 1});
        sb_q.push_back('{sel: 3'd1, head: 2'd0, cyc: t0 + 5});
        tick();
        init       = 1'b0;
        phase_done = 1'b1;
        tick();
        phase_done = 1'b0;
        tick();
        tick();
        chk("stray_still_wait_sel", int'(phase_sel), 0);
        chk("stray_starts", sb_q.size(), 1);
        phase_done = 1'b1;
        tick();
        phase_done = 1'b0;
        mode       = 0;
        for (int i = 2; i < 13; i++) begin
            sb_q.push_back('{sel: tbl[i].sel, head: tbl[i].head, cyc: t0 + 3 + 2 * i});
        end
        for (int k = 0; k < 100 && n_done == d0; k++) tick();
        chk("stray_done_cycle", done_cyc, t0 + 29);
        chk("stray_sb_empty", sb_q.size(), 0);

        // Asynchronous reset during the WAIT of (SOFTMAX,1).
        tick();
        t0   = cyc;
        d0   = n_done;
        init = 1'b1;
        push_all(t0);
        tick();
        init = 1'b0;
        for (int k = 0; k < 100 && cyc < t0 + 14; k++) tick();
        #2;
        mode       = 2;
        phase_done = 1'b0;
        chk("pre_rst_sel", int'(phase_sel), 2);
        chk("pre_rst_head", int'(head_idx), 1);
        chk("pre_rst_ready", int'(ready), 0);
        reset_n = 1'b0;
        #1;
        chk("rst_ready", int'(ready), 1);
        chk("rst_start", int'(phase_start), 0);
        chk("rst_sel", int'(phase_sel), 0);
        chk("rst_head", int'(head_idx), 0);
        chk("rst_done", int'(done), 0);
        sb_q.delete();
        repeat (3) tick();
        reset_n = 1'b1;
        mode    = 0;
        repeat (5) tick();
        chk("rst_no_done", n_done - d0, 0);
        run_pass(1'b0, "restart");

`ifdef MHA_SCHED_TIMEOUT_EN
        // Engine never answers: watchdog fires after 8 WAIT cycles.
        mode       = 2;
        phase_done = 1'b0;
        tick();
        t0   = cyc;
        d0   = n_done;
        init = 1'b1;
        sb_q.push_back('{sel: 3'd0, head: 2'd0, cyc: t0 + 1});
        tick();
        init = 1'b0;
        for (int k = 0; k < 100 && cyc < t0 + 9; k++) tick();
        chk("wd_err_before", int'(timeout_err), 0);
        chk("wd_ready_before", int'(ready), 0);
        tick();
        chk("wd_err_set", int'(timeout_err), 1);
        chk("wd_ready_after", int'(ready), 1);
        repeat (5) tick();
        chk("wd_no_done", n_done - d0, 0);
        chk("wd_err_sticky", int'(timeout_err), 1);
        sb_q.push_back('{sel: 3'd0, head: 2'd0, cyc: -1});
        init = 1'b1;
        tick();
        init = 1'b0;
        chk("wd_err_cleared", int'(timeout_err), 0);
        tick();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        chk("wd_sb_empty", sb_q.size(), 0);
`endif

        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
